// File: rtl/flash_req_bridge.sv
// Bridges a CPU valid/ready request port onto the SPI flash controller's level-held command inputs.
// One command in flight; responses are one-cycle pulses; a watchdog turns a hung command into an error.
module flash_req_bridge #(
   parameter int unsigned     TO_W    = 20,
   parameter logic [TO_W-1:0] TIMEOUT = 20'd100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [23:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic        flash_en,
   output logic        flash_write,
   output logic [23:0] flash_addr,
   output logic [31:0] flash_data_in,
   input  logic        flash_idle,
   input  logic [31:0] flash_data_out
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state_q;
   logic [TO_W-1:0] cnt_q;
   logic [TO_W-1:0] cnt_d;
   logic            timeout_hit;
   logic            req_ready_q;
   logic            resp_valid_q;
   logic            resp_err_q;
   logic [31:0]     resp_rdata_q;
   logic            flash_en_q;
   logic            flash_write_q;
   logic [23:0]     flash_addr_q;
   logic [31:0]     flash_data_q;

   // cnt_q holds the 1-based age of the command during the current ISSUE/WAIT cycle
   assign timeout_hit = (cnt_q == TIMEOUT);
   assign cnt_d       = timeout_hit ? cnt_q : cnt_q + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         req_ready_q   <= 1'b1;
         resp_valid_q  <= 1'b0;
         resp_err_q    <= 1'b0;
         resp_rdata_q  <= '0;
         flash_en_q    <= 1'b0;
         flash_write_q <= 1'b0;
         flash_addr_q  <= '0;
         flash_data_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  req_ready_q <= 1'b0;
                  if (req_addr[1:0] != 2'b00) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= '0;
                  end else begin
                     state_q       <= ISSUE;
                     flash_en_q    <= 1'b1;
                     flash_write_q <= req_write;
                     flash_addr_q  <= req_addr;
                     flash_data_q  <= req_wdata;
                     cnt_q         <= {{(TO_W-1){1'b0}}, 1'b1};
                  end
               end
            end
            ISSUE: begin
               if (timeout_hit) begin
                  flash_en_q   <= 1'b0;
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  resp_rdata_q <= '0;
               end else begin
                  cnt_q <= cnt_d;
                  if (!flash_idle) begin
                     flash_en_q <= 1'b0;
                     state_q    <= WAIT;
                  end
               end
            end
            WAIT: begin
               // the watchdog is checked first so a late completion still reports the error
               if (timeout_hit) begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  resp_rdata_q <= '0;
               end else if (flash_idle) begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= flash_write_q ? 32'd0 : flash_data_out;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            RESP: begin
               state_q      <= IDLE;
               req_ready_q  <= 1'b1;
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= '0;
               cnt_q        <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready     = req_ready_q;
   assign resp_valid    = resp_valid_q;
   assign resp_err      = resp_err_q;
   assign resp_rdata    = resp_rdata_q;
   assign flash_en      = flash_en_q;
   assign flash_write   = flash_write_q;
   assign flash_addr    = flash_addr_q;
   assign flash_data_in = flash_data_q;

endmodule

// File: tb/tb_flash_req_bridge.sv
// Directed bench for flash_req_bridge with a behavioural flash controller and a per-cycle reference model.
module tb_flash_req_bridge;

   localparam int TO = 50;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_write;
   logic [23:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        flash_en;
   logic        flash_write;
   logic [23:0] flash_addr;
   logic [31:0] flash_data_in;
   logic        flash_idle;
   logic [31:0] flash_data_out;

   flash_req_bridge #(.TO_W(20), .TIMEOUT(20'd50)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .flash_en(flash_en), .flash_write(flash_write), .flash_addr(flash_addr),
      .flash_data_in(flash_data_in), .flash_idle(flash_idle), .flash_data_out(flash_data_out)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Flash controller: goes busy the edge after it sees flash_en while idle, stays busy
   // busy_len cycles (forever when hang is set), then returns idle presenting rd_val.
   int          busy_len = 40;
   bit          hang = 1'b0;
   logic [31:0] rd_val = '0;
   int          busy_left = 0;
   logic        en_s;
   logic        rst_s;
   initial begin
      flash_idle = 1'b1;
      flash_data_out = '0;
      forever begin
         @(negedge clk);
         en_s = flash_en;
         rst_s = reset;
         @(posedge clk);
         #1;
         if (rst_s) begin
            flash_idle = 1'b1;
            busy_left = 0;
         end else if (flash_idle && en_s === 1'b1) begin
            flash_idle = 1'b0;
            busy_left = busy_len;
         end else if (!flash_idle && !hang) begin
            busy_left--;
            if (busy_left <= 0) begin
               flash_idle = 1'b1;
               flash_data_out = rd_val;
            end
         end
      end
   end

   // Reference model: transaction view of what the bridge owes in the current cycle.
   bit          chk_on = 1'b0;
   bit          m_busy, m_handed, m_resp, m_rerr, m_fw;
   int          m_age;
   logic [31:0] m_rdata, m_fd;
   logic [23:0] m_fa;
   initial begin
      forever begin
         @(negedge clk);
         if (chk_on) begin
            chk("req_ready", req_ready, !m_busy && !m_resp);
            chk("resp_valid", resp_valid, m_resp);
            chk("resp_err", resp_err, m_resp && m_rerr);
            chk("resp_rdata", resp_rdata, m_resp ? m_rdata : 32'd0);
            chk("flash_en", flash_en, m_busy && !m_handed);
            if (m_busy) begin
               chk("flash_addr", flash_addr, m_fa);
               chk("flash_write", flash_write, m_fw);
               chk("flash_data_in", flash_data_in, m_fd);
            end
         end
         if (reset) begin
            m_busy = 0; m_handed = 0; m_resp = 0; m_rerr = 0; m_age = 0;
            m_rdata = '0; m_fa = '0; m_fw = 0; m_fd = '0;
         end else if (m_resp) begin
            m_resp = 0;
         end else if (!m_busy) begin
            if (req_valid) begin
               if (req_addr % 4 != 0) begin
                  m_resp = 1; m_rerr = 1; m_rdata = '0;
               end else begin
                  m_busy = 1; m_handed = 0; m_age = 1;
                  m_fa = req_addr; m_fw = req_write; m_fd = req_wdata;
               end
            end
         end else if (m_age >= TO) begin
            m_busy = 0; m_resp = 1; m_rerr = 1; m_rdata = '0;
         end else if (!m_handed) begin
            if (!flash_idle) m_handed = 1;
            m_age++;
         end else if (flash_idle) begin
            m_busy = 0; m_resp = 1; m_rerr = 0;
            m_rdata = m_fw ? 32'd0 : flash_data_out;
         end else begin
            m_age++;
         end
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".req_ready"}, req_ready, 1);
      chk({tag, ".resp_valid"}, resp_valid, 0);
      chk({tag, ".resp_err"}, resp_err, 0);
      chk({tag, ".resp_rdata"}, resp_rdata, 0);
      chk({tag, ".flash_en"}, flash_en, 0);
      chk({tag, ".flash_write"}, flash_write, 0);
      chk({tag, ".flash_addr"}, flash_addr, 0);
      chk({tag, ".flash_data_in"}, flash_data_in, 0);
   endtask

   // Issue one request; lat counts cycles from the accept edge to the resp_valid cycle.
   task automatic do_req(input bit w, input logic [23:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd, output logic [31:0] er,
                         output int enc);
      int k;
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (req_ready !== 1'b1 && k < 200);
      if (k >= 200) chk("accept_wait", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 0; rd = 'x; er = 'x; enc = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (flash_en === 1'b1) enc++;
         if (resp_valid === 1'b1) begin
            lat = i; rd = resp_rdata; er = {31'd0, resp_err};
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input string nm, input bit w, input logic [23:0] a, input logic [31:0] d,
                      input int e_lat, input logic [31:0] e_rd, input logic [31:0] e_er, input int e_enc);
      int lat, enc;
      logic [31:0] rd, er;
      do_req(w, a, d, lat, rd, er, enc);
      chk({nm, ".latency"}, lat, e_lat);
      chk({nm, ".rdata"}, rd, e_rd);
      chk({nm, ".err"}, er, e_er);
      chk({nm, ".en_cycles"}, enc, e_enc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, pulses;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_on = 1'b1;
      @(negedge clk);
      chk_reset_vals("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      busy_len = 40; rd_val = 32'hdeadbeef;
      run("write", 1'b1, 24'h00eebc, 32'h8cef8cef, 43, 32'h0, 32'h0, 2);
      rd_val = 32'h8cef8cef;
      run("read", 1'b0, 24'h00eebc, 32'h0, 43, 32'h8cef8cef, 32'h0, 2);
      run("misaligned", 1'b0, 24'h00eebb, 32'h0, 1, 32'h0, 32'h1, 0);
      busy_len = 5; rd_val = 32'h12345678;
      run("short_read", 1'b0, 24'h000100, 32'h0, 8, 32'h12345678, 32'h0, 2);

      hang = 1'b1;
      run("timeout", 1'b1, 24'h000200, 32'hcafef00d, 51, 32'h0, 32'h1, 2);
      hang = 1'b0;
      k = 0;
      while (flash_idle !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
      if (k >= 100) chk("ctl_release", 32'd0, 32'd1);
      busy_len = 3; rd_val = 32'ha5a55a5a;
      run("after_timeout", 1'b0, 24'h000004, 32'h0, 6, 32'ha5a55a5a, 32'h0, 2);

      busy_len = 47; rd_val = 32'h11112222;
      run("just_in_time", 1'b0, 24'h000008, 32'h0, 50, 32'h11112222, 32'h0, 2);
      busy_len = 48;
      run("tie_err_wins", 1'b0, 24'h00000c, 32'h0, 51, 32'h0, 32'h1, 2);

      busy_len = 40; rd_val = 32'h77778888;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 24'h00eebc;
      @(negedge clk);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk_reset_vals("mid_reset");
      pulses = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (resp_valid === 1'b1) pulses++;
      end
      chk("mid_reset.no_resp", pulses, 0);
      @(posedge clk);
      #1;
      busy_len = 4; rd_val = 32'h0badf00d;
      run("read_after_reset", 1'b0, 24'h000eec, 32'h0, 7, 32'h0badf00d, 32'h0, 2);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
